// File: rtl/dsp48a1_mac_sequencer.sv
// Operand sequencer for one DSP48A1 slice used as a multiply-accumulate engine.
// Issues A/B/C/OPMODE per frame tap and captures P once the frame's last product has landed.
module dsp48a1_mac_sequencer #(
    parameter int N_TAPS     = 4,
    parameter int PIPE_LAT   = 3,
    parameter int OPMODE_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    input  logic [47:0] in_c,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [47:0] dsp_c,
    output logic [7:0]  dsp_opmode,
    input  logic [47:0] dsp_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data
);

    localparam int              TW      = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [TW-1:0]   LAST    = TW'(N_TAPS - 1);
    localparam logic [7:0]      OP_TAP0 = 8'h0D;
    localparam logic [7:0]      OP_ACC  = 8'h09;

    logic [TW-1:0]     tap_cnt;
    logic [PIPE_LAT:0] tag_p;
    logic [7:0]        op_p [OPMODE_DLY+1];
    logic              is_last;
    logic              accept;

    always_comb begin
        is_last  = (tap_cnt == LAST);
        in_ready = !is_last || ((tag_p == '0) && (!out_valid || out_ready));
        accept   = in_valid && in_ready && !clr;
    end

    assign dsp_opmode = op_p[OPMODE_DLY];

    // Stage p0: operand issue to slice A1/B1/C inputs; opcode enters the OPMODE delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a <= '0;
            dsp_b <= '0;
            dsp_c <= '0;
            // Output stage resets to 0x00 (clears P); inner stages hold idle so 0x09 appears on the first edge
            for (int i = 0; i <= OPMODE_DLY; i++)
                op_p[i] <= (i == OPMODE_DLY) ? 8'h00 : OP_ACC;
        end else begin
            dsp_a <= accept ? in_a : '0;
            dsp_b <= accept ? in_b : '0;
            if (accept && (tap_cnt == '0))
                dsp_c <= in_c;
            op_p[0] <= (accept && (tap_cnt == '0)) ? OP_TAP0 : OP_ACC;
            for (int i = 1; i <= OPMODE_DLY; i++)
                op_p[i] <= op_p[i-1];
        end
    end

    // Stage p1..pN: last-tap tag rides alongside the slice pipeline; capture P when it exits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt   <= '0;
            tag_p     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clr) begin
            tap_cnt   <= '0;
            tag_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept)
                tap_cnt <= is_last ? '0 : tap_cnt + TW'(1);
            tag_p <= {tag_p[PIPE_LAT-1:0], accept && is_last};
            if (tag_p[PIPE_LAT]) begin
                out_data  <= dsp_p;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Randomised and directed bench for dsp48a1_mac_sequencer with a behavioural slice
// and a frame-level accumulate reference.
module tb_dsp48a1_mac_sequencer;

    localparam int N_TAPS     = 4;
    localparam int PIPE_LAT   = 3;
    localparam int OPMODE_DLY = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_a = '0, in_b = '0;
    logic [47:0] in_c = '0;
    logic [17:0] dsp_a, dsp_b;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] out_data;

    dsp48a1_mac_sequencer #(.N_TAPS(N_TAPS), .PIPE_LAT(PIPE_LAT), .OPMODE_DLY(OPMODE_DLY)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_p(dsp_p), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural DSP48A1 slice: A1/B1, M, OPMODE, C and P registers
    logic [17:0] s_a1, s_b1;
    logic [35:0] s_m;
    logic [7:0]  s_op;
    logic [47:0] s_c, s_p;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_op <= '0; s_c <= '0; s_p <= '0;
        end else begin
            s_a1 <= dsp_a;
            s_b1 <= dsp_b;
            s_m  <= s_a1 * s_b1;
            s_op <= dsp_opmode;
            s_c  <= dsp_c;
            if (s_op == 8'h0D)      s_p <= s_c + 48'(s_m);
            else if (s_op == 8'h09) s_p <= s_p + 48'(s_m);
            else                    s_p <= '0;
        end
    end
    assign dsp_p = s_p;

    // Frame-level reference: result = C + sum(a*b) mod 2^48, one per N_TAPS accepted samples
    int          cyc = 0;
    int          m_tap = 0;
    logic [47:0] m_acc = '0;
    logic [47:0] exp_q[$];
    int          lat_q[$];
    logic        prev_ov = 1'b0;
    int          res_cnt = 0;
    logic [47:0] last_out = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_tap = 0; exp_q.delete(); lat_q.delete(); prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) begin
                    res_cnt++;
                    last_out = out_data;
                    if (lat_q.size() > 0) chk("latency", 64'(cyc - lat_q.pop_front()), 64'(PIPE_LAT + 1));
                    else chk("latency_extra", 1, 0);
                end
                if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
                else chk("unexpected_out", 1, 0);
                if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            prev_ov = out_valid && !out_ready;
            if (m_tap != N_TAPS - 1) chk("in_ready_nonlast", in_ready, 1);
            if (clr) begin
                m_tap = 0; exp_q.delete(); lat_q.delete(); prev_ov = 1'b0;
            end else if (in_valid && in_ready) begin
                if (m_tap == 0) m_acc = in_c;
                m_acc = m_acc + 48'(in_a) * 48'(in_b);
                if (m_tap == N_TAPS - 1) begin
                    exp_q.push_back(m_acc);
                    lat_q.push_back(cyc + 1);
                    m_tap = 0;
                end else begin
                    m_tap++;
                end
            end
        end
    end

    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c);
        int n = 0;
        in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic basic_frame();
        for (int t = 0; t < N_TAPS; t++) send(18'(t + 1), 18'd2, 48'd10);
    endtask

    int base;
    logic rnd_on;

    initial begin
        // Reset values
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dsp_a", dsp_a, 0);
        chk("rst_dsp_b", dsp_b, 0);
        chk("rst_dsp_c", dsp_c, 0);
        chk("rst_opmode", dsp_opmode, 8'h00);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("opmode_after_rst", dsp_opmode, 8'h09);

        // Basic frame then back-to-back max-operand frame
        basic_frame();
        for (int t = 0; t < N_TAPS; t++) send(18'h3FFFF, 18'h3FFFF, 48'd0);
        idle(4);
        chk("basic_result", last_out, 48'd30);
        idle(6);
        chk("max_result", last_out, 48'h0000_003F_FFE0_0004);

        // Bubbles between taps 1 and 2
        send(18'd1, 18'd2, 48'd10);
        send(18'd2, 18'd2, 48'd10);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bubble_a", dsp_a, 0);
            chk("bubble_b", dsp_b, 0);
            chk("bubble_op", dsp_opmode, 8'h09);
            if (k < 2) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        send(18'd3, 18'd2, 48'd10);
        send(18'd4, 18'd2, 48'd10);
        idle(8);
        chk("bubble_result", last_out, 48'd30);

        // Backpressure: result held, next frame's last tap stalled
        out_ready = 1'b0;
        basic_frame();
        for (int t = 0; t < N_TAPS - 1; t++) send(18'd5, 18'd7, 48'd100);
        in_a = 18'd5; in_b = 18'd7; in_c = 48'd100; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        chk("bp_held_valid", out_valid, 1);
        chk("bp_held_data", out_data, 48'd30);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(18'd5, 18'd7, 48'd100);
        idle(8);
        chk("bp_frame2", last_out, 48'd240);

        // Abort after tap 2, with a sample offered in the clr cycle
        base = res_cnt;
        for (int t = 0; t < 3; t++) send(18'd9, 18'd9, 48'd1);
        clr = 1'b1; in_valid = 1'b1; in_a = 18'd77; in_b = 18'd77; in_c = 48'd5;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        basic_frame();
        idle(10);
        chk("abort_count", 64'(res_cnt - base), 1);
        chk("abort_result", last_out, 48'd30);

        // Asynchronous reset mid-frame, off the clock edge
        send(18'd11, 18'd11, 48'd3);
        send(18'd12, 18'd12, 48'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_dsp_a", dsp_a, 0);
        chk("arst_opmode", dsp_opmode, 8'h00);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        base = res_cnt;
        basic_frame();
        idle(8);
        chk("arst_count", 64'(res_cnt - base), 1);
        chk("arst_result", last_out, 48'd30);

        // Randomised frames with gaps and random output backpressure
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join_none
        for (int f = 0; f < 30; f++) begin
            logic [47:0] c;
            c = 48'({$urandom(), $urandom()});
            for (int t = 0; t < N_TAPS; t++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(18'($urandom()), 18'($urandom()), c);
            end
        end
        rnd_on = 1'b0;
        idle(40);
        chk("drain_empty", 64'(exp_q.size()), 0);
        chk("drain_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule
